// File: rtl/cpu_pkg.sv
// Shared constants and types for the memory responder: I/O addresses,
// status-register bit positions and the slot-grant encoding.
package cpu_pkg;

   localparam logic [15:0] IO_BASE   = 16'hFFF0;
   localparam logic [15:0] KEY_ADDR  = 16'hFFFE;
   localparam logic [15:0] STAT_ADDR = 16'hFFFD;

   localparam int STAT_NONEMPTY = 0;
   localparam int STAT_FULL     = 1;
   localparam int STAT_OVF      = 2;

   typedef enum logic {
      GNT_CPU = 1'b0,
      GNT_VID = 1'b1
   } gnt_e;

endpackage

// File: rtl/mem_responder_key_fifo.sv
// Keyboard scan-code FIFO with a sticky overflow flag. A pop of an empty FIFO
// is ignored; a push into a full FIFO lands only if a pop frees a slot.
module key_fifo #(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  logic [7:0] push_data,
   input  logic       pop,
   input  logic       ovf_clr,
   output logic [7:0] head,
   output logic       full,
   output logic       empty,
   output logic       ovf
);

   localparam int PW = $clog2(DEPTH) + 1;
   localparam int IW = PW - 1;

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic          ovf_q, ovf_d;
   logic [7:0]    mem_q [DEPTH];
   logic          pop_ok;
   logic          push_ok;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                    (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]);
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);
   assign head    = mem_q[rd_ptr_q[IW-1:0]];
   assign ovf     = ovf_q;

   always_comb begin
      rd_ptr_d = rd_ptr_q + PW'(pop_ok);
      wr_ptr_d = wr_ptr_q + PW'(push_ok);
      ovf_d    = (ovf_q && !ovf_clr) || (push && !push_ok);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         ovf_q    <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q[IW-1:0]] <= push_data;
   end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: program/data RAM, keyboard FIFO and status register
// for the CPU, with a read-only video port slotted into idle CPU cycles.
module mem_responder #(
   parameter int          DEPTH      = 16384,
   parameter logic [15:0] IO_BASE    = cpu_pkg::IO_BASE,
   parameter logic [15:0] KEY_ADDR   = cpu_pkg::KEY_ADDR,
   parameter logic [15:0] STAT_ADDR  = cpu_pkg::STAT_ADDR,
   parameter int          FIFO_DEPTH = 4,
   parameter int          MAXWAIT    = 8
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        CpuEn,
   input  logic [15:0] CpuAddr,
   input  logic [15:0] CpuWrData,
   input  logic        MemWrEn,
   output logic [15:0] CpuRdData,
   output logic        CpuStall,
   input  logic        VidReq,
   input  logic [15:0] VidAddr,
   output logic        VidAck,
   output logic [15:0] VidData,
   input  logic        KeyStrobe,
   input  logic [7:0]  KeyCode
);

   import cpu_pkg::*;

   localparam int              AW        = $clog2(DEPTH);
   localparam int              WW        = $clog2(MAXWAIT + 1);
   localparam logic [16:0]     DEPTH_L   = 17'(DEPTH);
   localparam logic [WW-1:0]   MAXWAIT_L = WW'(MAXWAIT);

   logic [15:0]   ram [DEPTH];
   logic [WW-1:0] wait_cnt_q, wait_cnt_d;
   logic          vid_ack_q, vid_ack_d;
   logic [15:0]   vid_data_q, vid_data_d;
   logic [15:0]   cpu_rd_data_q, cpu_rd_data_d;
   gnt_e          gnt;
   logic          vid_req_eff;
   logic          cpu_go;
   logic          cpu_rd;
   logic          cpu_ram_hit;
   logic          vid_ram_hit;
   logic          io_sel;
   logic          key_sel;
   logic          stat_sel;
   logic          ram_we;
   logic          fifo_pop;
   logic          fifo_ovf_clr;
   logic          fifo_full;
   logic          fifo_empty;
   logic          fifo_ovf;
   logic [7:0]    fifo_head;

   // The requester still holds VidReq during its ack cycle; that level is stale.
   assign vid_req_eff = VidReq && !vid_ack_q;
   assign gnt         = (vid_req_eff && (!CpuEn || wait_cnt_q == MAXWAIT_L)) ? GNT_VID : GNT_CPU;
   assign cpu_go      = CpuEn && (gnt == GNT_CPU);
   assign cpu_rd      = cpu_go && !MemWrEn;
   assign CpuStall    = CpuEn && (gnt == GNT_VID);

   assign cpu_ram_hit  = {1'b0, CpuAddr} < DEPTH_L;
   assign vid_ram_hit  = {1'b0, VidAddr} < DEPTH_L;
   assign io_sel       = CpuAddr >= IO_BASE;
   assign key_sel      = io_sel && (CpuAddr == KEY_ADDR);
   assign stat_sel     = io_sel && (CpuAddr == STAT_ADDR);
   assign fifo_pop     = cpu_rd && key_sel;
   assign fifo_ovf_clr = cpu_rd && stat_sel;
   // Gating with Reset keeps a store from landing on an edge taken during reset.
   assign ram_we       = cpu_go && MemWrEn && cpu_ram_hit && Reset;

   assign CpuRdData = cpu_rd_data_q;
   assign VidAck    = vid_ack_q;
   assign VidData   = vid_data_q;

   key_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_key_fifo (
      .clk       (Clk),
      .rst_n     (Reset),
      .push      (KeyStrobe),
      .push_data (KeyCode),
      .pop       (fifo_pop),
      .ovf_clr   (fifo_ovf_clr),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .ovf       (fifo_ovf)
   );

   always_comb begin
      wait_cnt_d = '0;
      if (vid_req_eff && gnt == GNT_CPU)
         wait_cnt_d = (wait_cnt_q == MAXWAIT_L) ? wait_cnt_q : wait_cnt_q + WW'(1);

      vid_ack_d  = (gnt == GNT_VID);
      vid_data_d = vid_data_q;
      if (gnt == GNT_VID)
         vid_data_d = vid_ram_hit ? ram[VidAddr[AW-1:0]] : 16'h0000;

      cpu_rd_data_d = cpu_rd_data_q;
      if (cpu_rd) begin
         cpu_rd_data_d = 16'h0000;
         if (cpu_ram_hit) begin
            cpu_rd_data_d = ram[CpuAddr[AW-1:0]];
         end else if (key_sel) begin
            if (!fifo_empty) cpu_rd_data_d = {1'b1, 7'b0, fifo_head};
         end else if (stat_sel) begin
            cpu_rd_data_d[STAT_NONEMPTY] = !fifo_empty;
            cpu_rd_data_d[STAT_FULL]     = fifo_full;
            cpu_rd_data_d[STAT_OVF]      = fifo_ovf;
         end
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         wait_cnt_q    <= '0;
         vid_ack_q     <= 1'b0;
         vid_data_q    <= 16'h0000;
         cpu_rd_data_q <= 16'h0000;
      end else begin
         wait_cnt_q    <= wait_cnt_d;
         vid_ack_q     <= vid_ack_d;
         vid_data_q    <= vid_data_d;
         cpu_rd_data_q <= cpu_rd_data_d;
      end
   end

   always_ff @(posedge Clk) begin
      if (ram_we) ram[CpuAddr[AW-1:0]] <= CpuWrData;
   end

endmodule
